// File: rtl/mem_stage.sv
// Memory-access stage: registers EX results toward write-back and runs
// aligned load/store transactions on a req/ack data bus with a timeout.
module mem_stage #(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [4:0]  wreg_addr_i,
  input  logic        wreg_enable_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_wreg_addr_o,
  output logic        wb_wreg_enable_o,
  output logic [31:0] wb_wdata_o,
  output logic        exc_o,
  output logic [1:0]  exc_code_o
);

  localparam int unsigned CNT_W = 8;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;
  localparam logic [1:0] EXC_TMO  = 2'd3;

  typedef enum logic {IDLE, BUS} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [1:0]         lane_q, lane_d;
  logic [4:0]         cap_addr_q, cap_addr_d;
  logic               cap_en_q, cap_en_d;

  logic               bus_req_d, bus_we_d;
  logic [31:0]        bus_addr_d, bus_wdata_d;
  logic [3:0]         bus_sel_d;
  logic               wb_valid_d, wb_en_d, exc_d;
  logic [4:0]         wb_addr_d;
  logic [31:0]        wb_wdata_d;
  logic [1:0]         exc_code_d;

  logic               in_load, in_store, in_half, in_word, misaligned;
  logic               cap_load;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        load_val;

  assign stall_o = (state_q == BUS);

  // Decode of the incoming opcode and its alignment requirement
  always_comb begin
    in_load    = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
    in_store   = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    in_half    = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
    in_word    = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
    misaligned = (in_half && wdata_i[0]) || (in_word && (wdata_i[1:0] != 2'b00));
  end

  // Lane selection and sign/zero extension of returned read data
  always_comb begin
    cap_load = (op_q >= OP_LB) && (op_q <= OP_LW);
    rd_byte  = bus_rdata_i[{lane_q, 3'b000} +: 8];
    rd_half  = bus_rdata_i[{lane_q[1], 4'b0000} +: 16];
    unique case (op_q)
      OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_val = {24'h000000, rd_byte};
      OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_val = {16'h0000, rd_half};
      default: load_val = bus_rdata_i;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    lane_d      = lane_q;
    cap_addr_d  = cap_addr_q;
    cap_en_d    = cap_en_q;
    bus_req_d   = bus_req_o;
    bus_we_d    = bus_we_o;
    bus_addr_d  = bus_addr_o;
    bus_sel_d   = bus_sel_o;
    bus_wdata_d = bus_wdata_o;
    wb_valid_d  = 1'b0;
    wb_addr_d   = wb_wreg_addr_o;
    wb_en_d     = wb_wreg_enable_o;
    wb_wdata_d  = wb_wdata_o;
    exc_d       = 1'b0;
    exc_code_d  = exc_code_o;

    unique case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (!(in_load || in_store)) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = wreg_addr_i;
            wb_en_d    = wreg_enable_i;
            wb_wdata_d = wdata_i;
            exc_code_d = EXC_NONE;
          end else if (misaligned) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = wreg_addr_i;
            wb_en_d    = 1'b0;
            wb_wdata_d = wdata_i;
            exc_d      = 1'b1;
            exc_code_d = in_load ? EXC_ADEL : EXC_ADES;
          end else begin
            state_d    = BUS;
            cnt_d      = '0;
            op_d       = mem_op_i;
            lane_d     = wdata_i[1:0];
            cap_addr_d = wreg_addr_i;
            cap_en_d   = wreg_enable_i;
            bus_req_d  = 1'b1;
            bus_we_d   = in_store;
            bus_addr_d = {wdata_i[31:2], 2'b00};
            if (in_word) begin
              bus_sel_d   = 4'b1111;
              bus_wdata_d = store_data_i;
            end else if (in_half) begin
              bus_sel_d   = wdata_i[1] ? 4'b1100 : 4'b0011;
              bus_wdata_d = {2{store_data_i[15:0]}};
            end else begin
              bus_sel_d   = 4'b0001 << wdata_i[1:0];
              bus_wdata_d = {4{store_data_i[7:0]}};
            end
          end
        end
      end
      BUS: begin
        if (bus_ack_i) begin
          state_d    = IDLE;
          bus_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_addr_d  = cap_addr_q;
          wb_en_d    = cap_load ? cap_en_q : 1'b0;
          wb_wdata_d = load_val;
          exc_code_d = EXC_NONE;
        end else if (cnt_q == CNT_W'(BUS_TIMEOUT - 1)) begin
          state_d    = IDLE;
          bus_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_addr_d  = cap_addr_q;
          wb_en_d    = 1'b0;
          exc_d      = 1'b1;
          exc_code_d = EXC_TMO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      op_q             <= '0;
      lane_q           <= '0;
      cap_addr_q       <= '0;
      cap_en_q         <= 1'b0;
      bus_req_o        <= 1'b0;
      bus_we_o         <= 1'b0;
      bus_addr_o       <= '0;
      bus_sel_o        <= '0;
      bus_wdata_o      <= '0;
      wb_valid_o       <= 1'b0;
      wb_wreg_addr_o   <= '0;
      wb_wreg_enable_o <= 1'b0;
      wb_wdata_o       <= '0;
      exc_o            <= 1'b0;
      exc_code_o       <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      op_q             <= op_d;
      lane_q           <= lane_d;
      cap_addr_q       <= cap_addr_d;
      cap_en_q         <= cap_en_d;
      bus_req_o        <= bus_req_d;
      bus_we_o         <= bus_we_d;
      bus_addr_o       <= bus_addr_d;
      bus_sel_o        <= bus_sel_d;
      bus_wdata_o      <= bus_wdata_d;
      wb_valid_o       <= wb_valid_d;
      wb_wreg_addr_o   <= wb_addr_d;
      wb_wreg_enable_o <= wb_en_d;
      wb_wdata_o       <= wb_wdata_d;
      exc_o            <= exc_d;
      exc_code_o       <= exc_code_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a 4-cycle bus timeout.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [4:0]  wreg_addr_i;
  logic        wreg_enable_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] store_data_i;
  logic        stall_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_wreg_addr_o;
  logic        wb_wreg_enable_o;
  logic [31:0] wb_wdata_o;
  logic        exc_o;
  logic [1:0]  exc_code_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.BUS_TIMEOUT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid_i       (ex_valid_i),
    .wreg_addr_i      (wreg_addr_i),
    .wreg_enable_i    (wreg_enable_i),
    .wdata_i          (wdata_i),
    .mem_op_i         (mem_op_i),
    .store_data_i     (store_data_i),
    .stall_o          (stall_o),
    .bus_req_o        (bus_req_o),
    .bus_we_o         (bus_we_o),
    .bus_addr_o       (bus_addr_o),
    .bus_sel_o        (bus_sel_o),
    .bus_wdata_o      (bus_wdata_o),
    .bus_ack_i        (bus_ack_i),
    .bus_rdata_i      (bus_rdata_i),
    .wb_valid_o       (wb_valid_o),
    .wb_wreg_addr_o   (wb_wreg_addr_o),
    .wb_wreg_enable_o (wb_wreg_enable_o),
    .wb_wdata_o       (wb_wdata_o),
    .exc_o            (exc_o),
    .exc_code_o       (exc_code_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [4:0] rd, input logic en, input logic [31:0] sd);
    ex_valid_i    = 1'b1;
    mem_op_i      = op;
    wdata_i       = addr;
    wreg_addr_i   = rd;
    wreg_enable_i = en;
    store_data_i  = sd;
  endtask

  initial begin
    rst          = 1'b0;
    bus_ack_i    = 1'b0;
    bus_rdata_i  = 32'hA5A5A5A5;
    issue(4'd5, 32'h0000FFFF, 5'd31, 1'b1, 32'hFFFFFFFF);

    // Reset held with a valid instruction presented
    repeat (3) step();
    check("rst_stall",  32'(stall_o), 32'd0);
    check("rst_req",    32'(bus_req_o), 32'd0);
    check("rst_we",     32'(bus_we_o), 32'd0);
    check("rst_addr",   bus_addr_o, 32'd0);
    check("rst_sel",    32'(bus_sel_o), 32'd0);
    check("rst_bwdata", bus_wdata_o, 32'd0);
    check("rst_wbv",    32'(wb_valid_o), 32'd0);
    check("rst_wbaddr", 32'(wb_wreg_addr_o), 32'd0);
    check("rst_wben",   32'(wb_wreg_enable_o), 32'd0);
    check("rst_wbdata", wb_wdata_o, 32'd0);
    check("rst_exc",    32'(exc_o), 32'd0);
    check("rst_code",   32'(exc_code_o), 32'd0);

    // NONE op passes through in one cycle
    rst = 1'b1;
    issue(4'd0, 32'h00001234, 5'd5, 1'b1, 32'd0);
    step();
    ex_valid_i = 1'b0;
    check("none_v",    32'(wb_valid_o), 32'd1);
    check("none_addr", 32'(wb_wreg_addr_o), 32'd5);
    check("none_en",   32'(wb_wreg_enable_o), 32'd1);
    check("none_data", wb_wdata_o, 32'h00001234);
    check("none_stall", 32'(stall_o), 32'd0);
    step();
    check("none_pulse", 32'(wb_valid_o), 32'd0);
    check("none_hold",  wb_wdata_o, 32'h00001234);

    // LB from byte 3, ack in third BUS cycle
    issue(4'd1, 32'h00001003, 5'd7, 1'b1, 32'd0);
    step();
    ex_valid_i = 1'b0;
    check("lb_req",   32'(bus_req_o), 32'd1);
    check("lb_we",    32'(bus_we_o), 32'd0);
    check("lb_addr",  bus_addr_o, 32'h00001000);
    check("lb_sel",   32'(bus_sel_o), 32'b1000);
    check("lb_stall1", 32'(stall_o), 32'd1);
    step();
    check("lb_stall2", 32'(stall_o), 32'd1);
    check("lb_wbv_busy", 32'(wb_valid_o), 32'd0);
    step();
    check("lb_stall3", 32'(stall_o), 32'd1);
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h80FF0000;
    step();
    bus_ack_i = 1'b0;
    check("lb_stall_end", 32'(stall_o), 32'd0);
    check("lb_req_end", 32'(bus_req_o), 32'd0);
    check("lb_wbv",   32'(wb_valid_o), 32'd1);
    check("lb_wbaddr", 32'(wb_wreg_addr_o), 32'd7);
    check("lb_wben",  32'(wb_wreg_enable_o), 32'd1);
    check("lb_data",  wb_wdata_o, 32'hFFFFFF80);
    check("lb_exc",   32'(exc_o), 32'd0);

    // LBU same access, zero-extended
    issue(4'd2, 32'h00001003, 5'd8, 1'b1, 32'd0);
    step();
    ex_valid_i = 1'b0;
    check("lbu_sel", 32'(bus_sel_o), 32'b1000);
    step();
    step();
    bus_ack_i = 1'b1;
    step();
    bus_ack_i = 1'b0;
    check("lbu_wbv",  32'(wb_valid_o), 32'd1);
    check("lbu_data", wb_wdata_o, 32'h00000080);

    // SH to upper half, ack in first BUS cycle
    issue(4'd7, 32'h00002002, 5'd9, 1'b1, 32'hDEADBEEF);
    step();
    ex_valid_i = 1'b0;
    check("sh_req",   32'(bus_req_o), 32'd1);
    check("sh_we",    32'(bus_we_o), 32'd1);
    check("sh_addr",  bus_addr_o, 32'h00002000);
    check("sh_sel",   32'(bus_sel_o), 32'b1100);
    check("sh_wdata", bus_wdata_o, 32'hBEEFBEEF);
    bus_ack_i = 1'b1;
    step();
    bus_ack_i = 1'b0;
    check("sh_wbv",  32'(wb_valid_o), 32'd1);
    check("sh_wben", 32'(wb_wreg_enable_o), 32'd0);
    check("sh_exc",  32'(exc_o), 32'd0);
    check("sh_req_end", 32'(bus_req_o), 32'd0);

    // Misaligned LW then SW back to back, then a NONE op
    issue(4'd5, 32'h00003001, 5'd10, 1'b1, 32'd0);
    step();
    check("adel_req",  32'(bus_req_o), 32'd0);
    check("adel_stall", 32'(stall_o), 32'd0);
    check("adel_wbv",  32'(wb_valid_o), 32'd1);
    check("adel_wben", 32'(wb_wreg_enable_o), 32'd0);
    check("adel_exc",  32'(exc_o), 32'd1);
    check("adel_code", 32'(exc_code_o), 32'd1);
    issue(4'd8, 32'h00003002, 5'd11, 1'b1, 32'h12345678);
    step();
    check("ades_req",  32'(bus_req_o), 32'd0);
    check("ades_exc",  32'(exc_o), 32'd1);
    check("ades_code", 32'(exc_code_o), 32'd2);
    issue(4'd0, 32'h0000ABCD, 5'd12, 1'b1, 32'd0);
    step();
    ex_valid_i = 1'b0;
    check("post_wbv",  32'(wb_valid_o), 32'd1);
    check("post_exc",  32'(exc_o), 32'd0);
    check("post_code", 32'(exc_code_o), 32'd0);
    check("post_data", wb_wdata_o, 32'h0000ABCD);
    check("post_en",   32'(wb_wreg_enable_o), 32'd1);
    step();
    check("post_pulse", 32'(wb_valid_o), 32'd0);

    // LW with no ack: request held 4 cycles, then timeout
    issue(4'd5, 32'h00004000, 5'd3, 1'b1, 32'd0);
    step();
    ex_valid_i = 1'b0;
    check("tmo_sel", 32'(bus_sel_o), 32'hF);
    for (int i = 0; i < 3; i++) begin
      check("tmo_req_hold", 32'(bus_req_o), 32'd1);
      step();
    end
    check("tmo_req_last", 32'(bus_req_o), 32'd1);
    step();
    check("tmo_req_drop", 32'(bus_req_o), 32'd0);
    check("tmo_stall", 32'(stall_o), 32'd0);
    check("tmo_wbv",  32'(wb_valid_o), 32'd1);
    check("tmo_wben", 32'(wb_wreg_enable_o), 32'd0);
    check("tmo_exc",  32'(exc_o), 32'd1);
    check("tmo_code", 32'(exc_code_o), 32'd3);
    step();
    check("tmo_exc_pulse", 32'(exc_o), 32'd0);
    check("tmo_wbv_pulse", 32'(wb_valid_o), 32'd0);

    // LW with ack on the last permitted cycle completes normally
    issue(4'd5, 32'h00004000, 5'd4, 1'b1, 32'd0);
    step();
    ex_valid_i = 1'b0;
    step();
    step();
    step();
    check("edge_req", 32'(bus_req_o), 32'd1);
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h11223344;
    step();
    bus_ack_i = 1'b0;
    check("edge_wbv",  32'(wb_valid_o), 32'd1);
    check("edge_exc",  32'(exc_o), 32'd0);
    check("edge_code", 32'(exc_code_o), 32'd0);
    check("edge_wben", 32'(wb_wreg_enable_o), 32'd1);
    check("edge_data", wb_wdata_o, 32'h11223344);

    // Reset during BUS, ack arriving the following cycle is ignored
    issue(4'd5, 32'h00005000, 5'd6, 1'b1, 32'd0);
    step();
    ex_valid_i = 1'b0;
    check("mid_req", 32'(bus_req_o), 32'd1);
    rst = 1'b0;
    step();
    check("mid_req_rst", 32'(bus_req_o), 32'd0);
    check("mid_stall",   32'(stall_o), 32'd0);
    check("mid_wbv",     32'(wb_valid_o), 32'd0);
    rst       = 1'b1;
    bus_ack_i = 1'b1;
    step();
    bus_ack_i = 1'b0;
    check("mid_ack_wbv",  32'(wb_valid_o), 32'd0);
    check("mid_ack_req",  32'(bus_req_o), 32'd0);
    check("mid_ack_stall", 32'(stall_o), 32'd0);
    check("mid_ack_exc",  32'(exc_o), 32'd0);
    step();
    check("mid_after_wbv", 32'(wb_valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
